// File: rtl/ins_fetch_if.sv
// Bundle between the fetch sequencer and its control unit / instruction memory.
// The slave modport is the fetch unit; master is the control-unit and memory side.
interface ins_fetch_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          fetch_req;
    logic          pc_load;
    logic [AW-1:0] pc_new;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] ins_reg;
    logic          loadIR;
    logic          busy;
    logic [AW-1:0] pc;
    logic          fault;

    modport slave (
        input  fetch_req, pc_load, pc_new, mem_data,
        output mem_addr, mem_rd, ins_reg, loadIR, busy, pc, fault
    );

    modport master (
        output fetch_req, pc_load, pc_new, mem_data,
        input  mem_addr, mem_rd, ins_reg, loadIR, busy, pc, fault
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory and strobes loadIR.
// Define PC_WRAP_HALT_EN to make a PC increment past the top address a sticky fault.
module ins_fetch #(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    ins_fetch_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, LOAD} state_t;

    state_t        state;
    logic [CW-1:0] lat_cnt;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] jump_pc;
    logic          jump_pend;
    logic [DW-1:0] ins_q;
    logic          mem_rd_q;
    logic          load_q;
    logic [AW-1:0] next_pc;
    logic          halted;
    logic          stop_at_load;

    // A jump arriving in the LOAD cycle itself is the latest one, so it beats a latched target.
    always_comb begin
        next_pc = pc_q + 1'b1;
        if (bus.pc_load)
            next_pc = bus.pc_new;
        else if (jump_pend)
            next_pc = jump_pc;
    end

`ifdef PC_WRAP_HALT_EN
    logic fault_q;
    logic wrap_hit;

    assign wrap_hit     = !bus.pc_load && !jump_pend && (pc_q == {AW{1'b1}});
    assign halted       = fault_q;
    assign stop_at_load = fault_q | wrap_hit;
    assign bus.fault    = fault_q;

    // Sticky until software jumps somewhere sane from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_q <= 1'b0;
        else if (state == LOAD && wrap_hit)
            fault_q <= 1'b1;
        else if (state == IDLE && bus.pc_load)
            fault_q <= 1'b0;
    end
`else
    assign halted       = 1'b0;
    assign stop_at_load = 1'b0;
    assign bus.fault    = 1'b0;
`endif

    // Main sequencer: IDLE -> REQ -> WAIT (MEM_LAT cycles) -> LOAD, chaining straight to REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            pc_q       <= '0;
            mem_addr_q <= '0;
            jump_pc    <= '0;
            jump_pend  <= 1'b0;
            ins_q      <= '0;
            mem_rd_q   <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            load_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.pc_load)
                        pc_q <= bus.pc_new;
                    if (bus.fetch_req && !halted) begin
                        mem_addr_q <= bus.pc_load ? bus.pc_new : pc_q;
                        mem_rd_q   <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (bus.pc_load) begin
                        jump_pc   <= bus.pc_new;
                        jump_pend <= 1'b1;
                    end
                    lat_cnt <= CW'(MEM_LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (bus.pc_load) begin
                        jump_pc   <= bus.pc_new;
                        jump_pend <= 1'b1;
                    end
                    if (lat_cnt == CW'(1)) begin
                        ins_q  <= bus.mem_data;
                        load_q <= 1'b1;
                        state  <= LOAD;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    pc_q      <= next_pc;
                    jump_pend <= 1'b0;
                    if (bus.fetch_req && !stop_at_load) begin
                        mem_addr_q <= next_pc;
                        mem_rd_q   <= 1'b1;
                        state      <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.ins_reg  = ins_q;
    assign bus.loadIR   = load_q;
    assign bus.busy     = (state != IDLE);
    assign bus.pc       = pc_q;
endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each fed by a small synchronous memory model with the matching read latency.
module tb_ins_fetch;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mem [16];
    logic [7:0] p3 [3];

    ins_fetch_if #(.AW(4), .DW(8)) b1 ();
    ins_fetch_if #(.AW(4), .DW(8)) b3 ();

    ins_fetch #(.AW(4), .DW(8), .MEM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    ins_fetch #(.AW(4), .DW(8), .MEM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;

    // Memory with one cycle of read latency for dut1.
    always @(posedge clk)
        if (b1.mem_rd)
            b1.mem_data <= mem[b1.mem_addr];

    // Three-stage read pipeline for dut3.
    always @(posedge clk) begin
        if (b3.mem_rd)
            p3[0] <= mem[b3.mem_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b3.mem_data = p3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic fr, input logic pl, input logic [3:0] pn);
        b1.fetch_req = fr;
        b1.pc_load   = pl;
        b1.pc_new    = pn;
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] b2b [3];
        b2b[0] = 8'h11;
        b2b[1] = 8'h22;
        b2b[2] = 8'h33;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0]  = 8'hA5;
        mem[1]  = 8'h11;
        mem[2]  = 8'h22;
        mem[3]  = 8'h33;
        mem[12] = 8'h5C;
        mem[15] = 8'hF0;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 4'h0);
        b3.fetch_req = 1'b0;
        b3.pc_load   = 1'b0;
        b3.pc_new    = 4'h0;

        // Asynchronous reset takes effect before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_pc", {4'h0, b1.pc}, 8'h00);
        check_output("rst_addr", {4'h0, b1.mem_addr}, 8'h00);
        check_output("rst_rd", {7'h0, b1.mem_rd}, 8'h00);
        check_output("rst_ins", b1.ins_reg, 8'h00);
        check_output("rst_ld", {7'h0, b1.loadIR}, 8'h00);
        check_output("rst_busy", {7'h0, b1.busy}, 8'h00);
        check_output("rst_fault", {7'h0, b1.fault}, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("idle_rd", {7'h0, b1.mem_rd}, 8'h00);
            check_output("idle_ld", {7'h0, b1.loadIR}, 8'h00);
            check_output("idle_pc", {4'h0, b1.pc}, 8'h00);
        end

        $display("[TB] single fetch");
        apply_stimulus(1'b1, 1'b0, 4'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("sf_rd", {7'h0, b1.mem_rd}, 8'h01);
        check_output("sf_addr", {4'h0, b1.mem_addr}, 8'h00);
        check_output("sf_busy1", {7'h0, b1.busy}, 8'h01);
        tick();
        check_output("sf_ld_early", {7'h0, b1.loadIR}, 8'h00);
        tick();
        check_output("sf_ld", {7'h0, b1.loadIR}, 8'h01);
        check_output("sf_ins", b1.ins_reg, 8'hA5);
        check_output("sf_busy3", {7'h0, b1.busy}, 8'h01);
        check_output("sf_pc3", {4'h0, b1.pc}, 8'h00);
        tick();
        check_output("sf_pc4", {4'h0, b1.pc}, 8'h01);
        check_output("sf_busy4", {7'h0, b1.busy}, 8'h00);
        check_output("sf_ld4", {7'h0, b1.loadIR}, 8'h00);

        $display("[TB] back-to-back");
        apply_stimulus(1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("b2b_rd", {7'h0, b1.mem_rd}, 8'h01);
            check_output("b2b_addr", {4'h0, b1.mem_addr}, 8'(k + 1));
            check_output("b2b_ld_req", {7'h0, b1.loadIR}, 8'h00);
            tick();
            tick();
            check_output("b2b_ld", {7'h0, b1.loadIR}, 8'h01);
            check_output("b2b_ins", b1.ins_reg, b2b[k]);
            if (k == 2)
                apply_stimulus(1'b0, 1'b0, 4'h0);
        end
        tick();
        check_output("b2b_pc", {4'h0, b1.pc}, 8'h04);
        check_output("b2b_busy", {7'h0, b1.busy}, 8'h00);

        $display("[TB] jump mid-fetch");
        apply_stimulus(1'b0, 1'b1, 4'h2);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("jmp_idle_pc", {4'h0, b1.pc}, 8'h02);
        apply_stimulus(1'b1, 1'b0, 4'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("jmp_addr", {4'h0, b1.mem_addr}, 8'h02);
        tick();
        apply_stimulus(1'b0, 1'b1, 4'hC);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("jmp_ld", {7'h0, b1.loadIR}, 8'h01);
        check_output("jmp_ins", b1.ins_reg, 8'h22);
        check_output("jmp_pc_load", {4'h0, b1.pc}, 8'h02);
        tick();
        check_output("jmp_pc", {4'h0, b1.pc}, 8'h0C);
        apply_stimulus(1'b1, 1'b0, 4'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("jmp_addr2", {4'h0, b1.mem_addr}, 8'h0C);
        check_output("jmp_rd2", {7'h0, b1.mem_rd}, 8'h01);
        tick();
        tick();
        check_output("jmp_ins2", b1.ins_reg, 8'h5C);
        tick();
        check_output("jmp_pc2", {4'h0, b1.pc}, 8'h0D);

        $display("[TB] pc wrap");
        apply_stimulus(1'b0, 1'b1, 4'hF);
        tick();
        apply_stimulus(1'b1, 1'b0, 4'h0);
        check_output("wrap_pc_f", {4'h0, b1.pc}, 8'h0F);
        tick();
        check_output("wrap_addr_f", {4'h0, b1.mem_addr}, 8'h0F);
        tick();
        tick();
        check_output("wrap_ld", {7'h0, b1.loadIR}, 8'h01);
        check_output("wrap_ins", b1.ins_reg, 8'hF0);
        tick();
`ifdef PC_WRAP_HALT_EN
        check_output("wrap_fault", {7'h0, b1.fault}, 8'h01);
        check_output("wrap_busy", {7'h0, b1.busy}, 8'h00);
        check_output("wrap_pc0", {4'h0, b1.pc}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("halt_ld", {7'h0, b1.loadIR}, 8'h00);
            check_output("halt_busy", {7'h0, b1.busy}, 8'h00);
        end
        apply_stimulus(1'b0, 1'b1, 4'h3);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0);
        check_output("clr_fault", {7'h0, b1.fault}, 8'h00);
        check_output("clr_pc", {4'h0, b1.pc}, 8'h03);
`else
        check_output("wrap_pc0", {4'h0, b1.pc}, 8'h00);
        check_output("wrap_rd0", {7'h0, b1.mem_rd}, 8'h01);
        check_output("wrap_addr0", {4'h0, b1.mem_addr}, 8'h00);
        check_output("wrap_nofault", {7'h0, b1.fault}, 8'h00);
        tick();
        tick();
        check_output("wrap_ld2", {7'h0, b1.loadIR}, 8'h01);
        check_output("wrap_ins2", b1.ins_reg, 8'hA5);
        apply_stimulus(1'b0, 1'b0, 4'h0);
        tick();
        check_output("wrap_pc1", {4'h0, b1.pc}, 8'h01);
        check_output("wrap_idle", {7'h0, b1.busy}, 8'h00);
`endif

        $display("[TB] mid-cycle reset during fetch");
        apply_stimulus(1'b1, 1'b0, 4'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check_output("mrst_pc", {4'h0, b1.pc}, 8'h00);
        check_output("mrst_addr", {4'h0, b1.mem_addr}, 8'h00);
        check_output("mrst_rd", {7'h0, b1.mem_rd}, 8'h00);
        check_output("mrst_ins", b1.ins_reg, 8'h00);
        check_output("mrst_busy", {7'h0, b1.busy}, 8'h00);
        tick();
        rst_n = 1'b1;

        $display("[TB] reset mid-WAIT, MEM_LAT=3");
        b3.fetch_req = 1'b1;
        tick();
        b3.fetch_req = 1'b0;
        check_output("l3_rd", {7'h0, b3.mem_rd}, 8'h01);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_output("l3_rst_ld", {7'h0, b3.loadIR}, 8'h00);
        check_output("l3_rst_busy", {7'h0, b3.busy}, 8'h00);
        check_output("l3_rst_pc", {4'h0, b3.pc}, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("l3_quiet_ld", {7'h0, b3.loadIR}, 8'h00);
        end
        b3.fetch_req = 1'b1;
        tick();
        b3.fetch_req = 1'b0;
        check_output("l3_rd2", {7'h0, b3.mem_rd}, 8'h01);
        check_output("l3_addr2", {4'h0, b3.mem_addr}, 8'h00);
        tick();
        tick();
        tick();
        check_output("l3_ld_early", {7'h0, b3.loadIR}, 8'h00);
        tick();
        check_output("l3_ld", {7'h0, b3.loadIR}, 8'h01);
        check_output("l3_ins", b3.ins_reg, 8'hA5);
        tick();
        check_output("l3_pc", {4'h0, b3.pc}, 8'h01);
        check_output("l3_busy", {7'h0, b3.busy}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
